alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Multi-cycle, parametrised ALU with integrated op decode and a valid/ready handshake on both sides.
//  Sits between the decode stage (fmt/funct3/funct7) and writeback/branch logic of the core.
//  Adds the following over the combinational decoder generation:
//   - SRA and SLTU
//   - iterative shifts
//   - optional iterative MUL
//   - illegal-op flag
//   - compare flags
// PARAMETERS
//  XLEN  32  operand/result width; power of two, >= 8; SHW = $clog2(XLEN)
// PORTS
//  clk        in   1     clock; all state on rising edge
//  rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     operation request
//  in_ready   out  1     request accepted when in_valid & in_ready
//  fmt        in   4     0=R 1=I 2=S 3=B 4=J 5=U, others treated as ADD
//  funct3     in   3     instruction funct3
//  funct7     in   7     instruction funct7
//  op_a       in   XLEN  operand A
//  op_b       in   XLEN  operand B (imm for I/S/J/U); shamt = op_b[SHW-1:0]
//  out_valid  out  1     result available; held until out_ready
//  out_ready  in   1     consumer accepts when out_valid & out_ready
//  result     out  XLEN  operation result; stable while out_valid
//  zero       out  1     result == 0
//  lt         out  1     $signed(op_a) < $signed(op_b) of accepted request
//  ltu        out  1     op_a < op_b unsigned of accepted request
//  illegal    out  1     decoded op unsupported; result forced to 0
// BEHAVIOUR
//  Decode, R:
//   - f3=0: f7=00 ADD, f7=20 SUB, f7=01 MUL (macro only)
//   - f3=1 SLL, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND; each requires f7=00
//   - f3=5: f7=00 SRL, f7=20 SRA
//   - any other f7 -> illegal
//  Decode, I:
//   - f3=0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND; funct7 ignored
//   - f3=1 SLL requires f7=00
//   - f3=5: f7=00 SRL, f7=20 SRA
//   - else illegal
//  Decode, others: S/J/U ADD; B SUB; fmt 6..15 ADD, illegal=0.
//  Arithmetic:
//   - mod 2^XLEN, no overflow flag
//   - SLT/SLTU result is zero-extended 0/1
//   - MUL returns low XLEN bits
//  FSM states:
//   - IDLE: in_ready=1. On accept, latch op/operands/flags, then:
//     - single-cycle op or illegal -> DONE
//     - shift with shamt!=0 -> SHIFT
//     - shift with shamt=0 -> DONE
//     - MUL -> MUL
//   - SHIFT: shift acc 1 bit/cycle (SRA replicates sign); cnt-- ; cnt==1 -> DONE
//   - MUL: shift-add, 1 multiplier bit/cycle for XLEN cycles -> DONE
//   - DONE: out_valid=1; out_ready -> IDLE
//  Latency, accept edge to out_valid:
//   - single-cycle ops: 1
//   - shift: max(shamt,1)
//   - MUL: XLEN+1
//  Throughput: one op in flight; in_ready=0 outside IDLE.
//   - No same-cycle DONE->accept; the next accept is earliest the cycle after the out handshake.
//  Inputs are ignored outside IDLE; operand changes after accept have no effect.
//  zero/lt/ltu/illegal are registered with result and valid only while out_valid.
//  Reset:
//   - rst=1 in any state -> IDLE next edge; in-flight op discarded
//   - out_valid=0, result=0, flags=0, counters=0
//   - in_ready=1 from the first cycle after reset deasserts
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined:
//   - R f3=0 f7=01 decodes to MUL; MUL state present; latency XLEN+1
//  ALU_SEQ_MUL_EN undefined:
//   - that encoding -> illegal=1, result=0, latency 1
//   - no MUL state or multiplier logic synthesised
// STRUCTURE
//  Package alu_pkg:
//   - ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SLT 7, SRA 8, SLTU 9, MUL 10
//   - fmt codes R..U
//   - FSM state typedef
//  Sub-module alu_op_dec: combinational fmt/funct3/funct7 -> {op[3:0], illegal}.
//  Datapath and FSM live in alu_seq.
// TESTING
//  1. R ADD 0xFFFFFFFF+1: accept -> out_valid next cycle; result=0, zero=1, illegal=0.
//  2. I SRA, a=0x80000000, shamt=4: out_valid 4 cycles after accept; result=0xF8000000. SLL shamt=0 -> 1 cycle, result=a.
//  3. R SLTU a=1, b=0xFFFFFFFF: result=1, lt=0, ltu=1. SLT with same operands: result=0.
//  4. R f3=1, f7=0x20: illegal=1, result=0, latency 1. f7=01 f3=0 without macro: illegal=1.
//  5. Hold out_ready=0 for 5 cycles: result/flags stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE.
//  6. Assert rst mid-SHIFT (shamt=20, cycle 5): out_valid stays 0; post-reset ADD 2+3 returns 5.
//     With ALU_SEQ_MUL_EN: MUL 7*-3 -> 0xFFFFFFEB after 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, fmt codes and FSM state shared by alu_seq.
// ALU_SEQ_MUL_EN adds the iterative MUL op and its FSM state.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  localparam logic [3:0] FMT_R = 4'd0;
  localparam logic [3:0] FMT_I = 4'd1;
  localparam logic [3:0] FMT_S = 4'd2;
  localparam logic [3:0] FMT_B = 4'd3;
  localparam logic [3:0] FMT_J = 4'd4;
  localparam logic [3:0] FMT_U = 4'd5;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    S_MUL   = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_e;

  function automatic alu_op_e base_op(logic [2:0] f3);
    base_op = OP_ADD;
    case (f3)
      3'd1:    base_op = OP_SLL;
      3'd2:    base_op = OP_SLT;
      3'd3:    base_op = OP_SLTU;
      3'd4:    base_op = OP_XOR;
      3'd5:    base_op = OP_SRL;
      3'd6:    base_op = OP_OR;
      3'd7:    base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  endfunction

  function automatic logic is_shift(alu_op_e op);
    is_shift = op inside {OP_SLL, OP_SRL, OP_SRA};
  endfunction

endpackage

// File: rtl/alu_op_dec.sv
// alu_op_dec: fmt/funct3/funct7 -> {op, illegal}, purely combinational.
// ALU_SEQ_MUL_EN enables the R-type MUL encoding.
module alu_op_dec
  import alu_pkg::*;
(
  input  logic [3:0] i_fmt,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_op,
  output logic       o_illegal
);

  alu_op_e w_op;
  logic    w_ill;

  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    unique case (1'b1)
      (i_fmt == FMT_R): begin
        w_op = base_op(i_funct3);
        if (i_funct7 == F7_ALT && i_funct3 == 3'd0)
          w_op = OP_SUB;
        else if (i_funct7 == F7_ALT && i_funct3 == 3'd5)
          w_op = OP_SRA;
`ifdef ALU_SEQ_MUL_EN
        else if (i_funct7 == F7_MUL && i_funct3 == 3'd0)
          w_op = OP_MUL;
`endif
        else if (i_funct7 != F7_BASE)
          w_ill = 1'b1;
      end
      (i_fmt == FMT_I): begin
        w_op = base_op(i_funct3);
        if (i_funct3 == 3'd5 && i_funct7 == F7_ALT)
          w_op = OP_SRA;
        else if ((i_funct3 == 3'd1 || i_funct3 == 3'd5)
                 && i_funct7 != F7_BASE)
          w_ill = 1'b1;
      end
      (i_fmt == FMT_B): w_op = OP_SUB;
      default: ;
    endcase
  end

  assign o_op      = w_op;
  assign o_illegal = w_ill;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with op decode and valid/ready on both sides.
// ALU_SEQ_MUL_EN adds a shift-add multiplier (XLEN+1 cycle latency).
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      fmt,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  state_e          r_state;
  alu_op_e         r_op;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [SHW-1:0]  r_cnt;
  logic            r_zero;
  logic            r_lt;
  logic            r_ltu;
  logic            r_ill;

  logic [3:0]      w_dec_op;
  logic            w_dec_ill;
  alu_op_e         w_op;
  logic [SHW-1:0]  w_shamt;
  logic            w_lt;
  logic            w_ltu;
  logic            w_long_shift;
  logic [XLEN-1:0] w_res;
  logic [XLEN-1:0] w_sh_next;

`ifdef ALU_SEQ_MUL_EN
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] w_mul_sum;
`endif

  alu_op_dec u_dec (
    .i_fmt     (fmt),
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .o_op      (w_dec_op),
    .o_illegal (w_dec_ill)
  );

  function automatic logic [XLEN-1:0] shift1(
    alu_op_e op, logic [XLEN-1:0] v);
    case (op)
      OP_SLL:  shift1 = v << 1;
      OP_SRA:  shift1 = {v[XLEN-1], v[XLEN-1:1]};
      default: shift1 = v >> 1;
    endcase
  endfunction

  assign w_op    = alu_op_e'(w_dec_op);
  assign w_shamt = op_b[SHW-1:0];
  assign w_lt    = $signed(op_a) < $signed(op_b);
  assign w_ltu   = op_a < op_b;

  // The accept edge already does the first bit, so only shamt>1 iterates
  assign w_long_shift = is_shift(w_op) && (w_shamt > SHW'(1));
  assign w_sh_next    = shift1(r_op, r_acc);

`ifdef ALU_SEQ_MUL_EN
  assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_ADD:  w_res = op_a + op_b;
      OP_SUB:  w_res = op_a - op_b;
      OP_AND:  w_res = op_a & op_b;
      OP_OR:   w_res = op_a | op_b;
      OP_XOR:  w_res = op_a ^ op_b;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, w_ltu};
      OP_SLL, OP_SRL, OP_SRA:
        w_res = (w_shamt == '0) ? op_a : shift1(w_op, op_a);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_lt     <= 1'b0;
      r_ltu    <= 1'b0;
      r_ill    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= w_op;
            r_lt  <= w_lt;
            r_ltu <= w_ltu;
            r_ill <= w_dec_ill;
            if (w_dec_ill) begin
              r_result <= '0;
              r_zero   <= 1'b1;
              r_state  <= S_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (w_op == OP_MUL) begin
              r_acc    <= '0;
              r_cnt    <= '0;
              r_mcand  <= op_a;
              r_mplier <= op_b;
              r_state  <= S_MUL;
            end
`endif
            else if (w_long_shift) begin
              r_acc   <= shift1(w_op, op_a);
              r_cnt   <= w_shamt - SHW'(1);
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_res;
              r_zero   <= (w_res == '0);
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_sh_next;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_result <= w_sh_next;
            r_zero   <= (w_sh_next == '0);
            r_state  <= S_DONE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == SHW'(XLEN - 1)) begin
            r_result <= w_mul_sum;
            r_zero   <= (w_mul_sum == '0);
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end else begin
            r_acc <= w_mul_sum;
            r_cnt <= r_cnt + SHW'(1);
          end
        end
`endif
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign lt        = r_lt;
  assign ltu       = r_ltu;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against a spec model.
// Define ALU_SEQ_MUL_EN for both bench and RTL to exercise MUL.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  fmt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        ltu;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level reference: kind 0 add 1 sub 2 sll 3 slt 4 sltu
  // 5 xor 6 srl 7 sra 8 or 9 and 10 mul
  function automatic void ref_calc(
    input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7,
    input logic [31:0] a, input logic [31:0] b,
    output logic [31:0] r, output logic ill, output int lat);
    int k;
    int sh;
    int base [8];
    logic signed [31:0] sa;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    sh  = int'(b[4:0]);
    sa  = a;
    ill = 1'b0;
    k   = 0;
    if (f == 4'd0) begin
      if (f7 == 7'h00) k = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) k = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) k = 7;
      else if (f7 == 7'h01 && f3 == 3'd0) begin
`ifdef ALU_SEQ_MUL_EN
        k = 10;
`else
        ill = 1'b1;
`endif
      end else ill = 1'b1;
    end else if (f == 4'd1) begin
      k = base[f3];
      if (f3 == 3'd5 && f7 == 7'h20) k = 7;
      else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) ill = 1'b1;
    end else if (f == 4'd3) k = 1;
    case (k)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = (sa < $signed(b)) ? 32'd1 : 32'd0;
      4:  r = (a < b) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = a >> sh;
      7:  r = sa >>> sh;
      8:  r = a | b;
      9:  r = a & b;
      default: r = a * b;
    endcase
    lat = 1;
    if (k == 2 || k == 6 || k == 7) lat = (sh > 1) ? sh : 1;
    if (k == 10) lat = 33;
    if (ill) begin
      r   = 32'd0;
      lat = 1;
    end
  endfunction

  typedef enum {M_IDLE, M_BUSY, M_DONE} mph_e;
  mph_e        m_ph   = M_IDLE;
  bit          m_init = 1'b0;
  int          m_wait;
  int          m_lat;
  logic [31:0] m_res;
  logic        m_ill;
  logic        m_lt;
  logic        m_ltu;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   = M_IDLE;
      m_init = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          ref_calc(fmt, funct3, funct7, op_a, op_b, m_res, m_ill, m_lat);
          m_lt   = $signed(op_a) < $signed(op_b);
          m_ltu  = op_a < op_b;
          m_wait = m_lat - 1;
          m_ph   = (m_wait == 0) ? M_DONE : M_BUSY;
        end
        M_BUSY: begin
          m_wait--;
          if (m_wait == 0) m_ph = M_DONE;
        end
        default: if (out_ready) m_ph = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_ph == M_IDLE});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ph == M_DONE});
      if (m_ph == M_DONE && out_valid) begin
        chk("result", result, m_res);
        chk("zero", {31'd0, zero}, {31'd0, m_res == 32'd0});
        chk("lt", {31'd0, lt}, {31'd0, m_lt});
        chk("ltu", {31'd0, ltu}, {31'd0, m_ltu});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
      end
    end
  end

  task automatic issue(logic [3:0] f, logic [2:0] f3, logic [6:0] f7,
                       logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #1;
    fmt = f; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(string nm, logic [3:0] f, logic [2:0] f3,
                        logic [6:0] f7, logic [31:0] a, logic [31:0] b,
                        logic [31:0] er, int elat, logic eill);
    int lat;
    issue(f, f3, f7, a, b);
    wait_valid(lat);
    chk({nm, "_res"}, result, er);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_ill"}, {31'd0, illegal}, {31'd0, eill});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, zero, lt, ltu, illegal}, 32'd0);

    run_op("add_wrap", 4'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
    chk("add_wrap_zero", {31'd0, zero}, 32'd1);
    release_out();

    run_op("sra4", 4'd1, 3'd5, 7'h20, 32'h80000000, 32'd4,
           32'hF8000000, 4, 0);
    release_out();
    run_op("sll0", 4'd1, 3'd1, 7'h00, 32'h00001234, 32'd0,
           32'h00001234, 1, 0);
    release_out();

    run_op("sltu", 4'd0, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 1, 0);
    chk("sltu_lt", {31'd0, lt}, 32'd0);
    chk("sltu_ltu", {31'd0, ltu}, 32'd1);
    release_out();
    run_op("slt", 4'd0, 3'd2, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd0, 1, 0);
    release_out();

    run_op("ill_sll", 4'd0, 3'd1, 7'h20, 32'd9, 32'd3, 32'd0, 1, 1);
    release_out();
`ifdef ALU_SEQ_MUL_EN
    run_op("mul", 4'd0, 3'd0, 7'h01, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFEB, 33, 0);
`else
    run_op("mul_off", 4'd0, 3'd0, 7'h01, 32'd7, 32'hFFFFFFFD, 32'd0, 1, 1);
`endif
    release_out();

    run_op("hold", 4'd0, 3'd0, 7'h00, 32'd10, 32'd20, 32'd30, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      chk("hold_res", result, 32'd30);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    chk("hold_idle", {31'd0, in_ready}, 32'd1);

    issue(4'd0, 3'd1, 7'h00, 32'd1, 32'd20);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("rst_abort_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_rst_add", 4'd0, 3'd0, 7'h00, 32'd2, 32'd3, 32'd5, 1, 0);
    release_out();

    for (int c = 0; c < 4000; c++) begin
      int sel;
      @(posedge clk);
      #1;
      sel = $urandom_range(0, 9);
      fmt = (sel < 4) ? 4'd0 : (sel < 7) ? 4'd1 : 4'($urandom_range(0, 15));
      funct3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       funct7 = 7'h00;
        1:       funct7 = 7'h20;
        2:       funct7 = 7'h01;
        default: funct7 = 7'($urandom);
      endcase
      op_a = $urandom;
      op_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 31));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
